// File: rtl/rng_sched.sv
// Round-robin scheduler sharing a fixed-latency RNG datapath among N_REQ consumers.
// Optional per-requester delivery counters: define RNG_SCHED_STATS_EN.
module rng_sched #(
   parameter int N_REQ      = 4,
   parameter int BY         = 18,
   parameter int PIPE_LAT   = 3,
   parameter int FIFO_DEPTH = 4,
   localparam int TW        = $clog2(N_REQ)
) (
   input  logic             clock,
   input  logic             rst_n,
   input  logic             en,
   input  logic [N_REQ-1:0] req,
   output logic [N_REQ-1:0] gnt,
   input  logic             urng_valid,
   output logic             urng_ready,
   output logic             pipe_issue,
   output logic [TW-1:0]    pipe_tag,
   input  logic             pipe_out_valid,
   input  logic [BY-1:0]    pipe_out_data,
   output logic             out_valid,
   output logic [BY-1:0]    out_data,
   output logic [TW-1:0]    out_tag,
   input  logic             out_ready,
   output logic             busy,
   output logic             err
`ifdef RNG_SCHED_STATS_EN
   ,
   input  logic [TW-1:0]    stat_sel,
   output logic [31:0]      stat_cnt
`endif
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam int LW = $clog2(PIPE_LAT + 1);
   localparam int SW = CW + LW + 1;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_RUN   = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;

   logic [1:0]         state_q, state_d;
   logic [TW-1:0]      ptr_q, ptr_d;
   logic [PIPE_LAT-1:0] vld_q;
   logic [TW-1:0]      tag_q [PIPE_LAT];
   logic [BY+TW-1:0]   mem_q [FIFO_DEPTH];
   logic [PW-1:0]      rd_q, wr_q, rd_n;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [BY-1:0]      dat_q, dat_d;
   logic [TW-1:0]      otag_q, otag_d;
   logic               err_q, err_d;
   logic [TW-1:0]      gidx;
   logic               found, issue, push, pop, last_vld;
   logic [LW-1:0]      inflight;

   always_comb begin
      inflight = '0;
      for (int i = 0; i < PIPE_LAT; i++)
         inflight = inflight + LW'(vld_q[i]);
   end

   always_comb begin
      int j;
      j     = 0;
      gidx  = '0;
      found = 1'b0;
      for (int i = 0; i < N_REQ; i++) begin
         j = int'(ptr_q) + i;
         if (j >= N_REQ) j = j - N_REQ;
         if (!found && req[j]) begin
            found = 1'b1;
            gidx  = TW'(j);
         end
      end
   end

   // credit check ignores a same-cycle pop
   assign issue = (state_q == S_RUN) & urng_valid & (|req) &
                  ((SW'(inflight) + SW'(cnt_q)) < SW'(FIFO_DEPTH));

   assign gnt        = issue ? (N_REQ'(1) << gidx) : '0;
   assign urng_ready = issue;
   assign pipe_issue = issue;
   assign pipe_tag   = gidx;

   assign last_vld  = vld_q[PIPE_LAT-1];
   assign push      = last_vld;
   assign out_valid = (cnt_q != '0);
   assign pop       = out_valid & out_ready;
   assign out_data  = dat_q;
   assign out_tag   = otag_q;
   assign busy      = (state_q != S_IDLE);
   assign err       = err_q;

   always_comb begin
      ptr_d = ptr_q;
      if (issue)
         ptr_d = (gidx == TW'(N_REQ - 1)) ? '0 : gidx + TW'(1);
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:  if (en) state_d = S_RUN;
         S_RUN:   if (!en) state_d = S_DRAIN;
         S_DRAIN: begin
            if (en) state_d = S_RUN;
            else if (inflight == '0) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      err_d  = err_q | (last_vld ^ pipe_out_valid);
      cnt_d  = cnt_q + CW'(push) - CW'(pop);
      rd_n   = pop ? rd_q + PW'(1) : rd_q;
      dat_d  = dat_q;
      otag_d = otag_q;
      // head register tracks the entry that will be at rd_n next cycle
      if (cnt_d != '0) begin
         if (push && (wr_q == rd_n))
            {otag_d, dat_d} = {tag_q[PIPE_LAT-1], pipe_out_data};
         else
            {otag_d, dat_d} = mem_q[rd_n];
      end
   end

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         ptr_q   <= '0;
         vld_q   <= '0;
         for (int i = 0; i < PIPE_LAT; i++)
            tag_q[i] <= '0;
         rd_q    <= '0;
         wr_q    <= '0;
         cnt_q   <= '0;
         dat_q   <= '0;
         otag_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         vld_q[0] <= issue;
         tag_q[0] <= gidx;
         for (int i = 1; i < PIPE_LAT; i++) begin
            vld_q[i] <= vld_q[i-1];
            tag_q[i] <= tag_q[i-1];
         end
         rd_q   <= rd_n;
         wr_q   <= push ? wr_q + PW'(1) : wr_q;
         cnt_q  <= cnt_d;
         dat_q  <= dat_d;
         otag_q <= otag_d;
         err_q  <= err_d;
      end
   end

   always_ff @(posedge clock) begin
      if (push)
         mem_q[wr_q] <= {tag_q[PIPE_LAT-1], pipe_out_data};
   end

`ifdef RNG_SCHED_STATS_EN
   logic [31:0] scnt_q [N_REQ];
   logic [31:0] stat_q;

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N_REQ; i++)
            scnt_q[i] <= '0;
         stat_q <= '0;
      end else begin
         if (pop)
            scnt_q[out_tag] <= scnt_q[out_tag] + 32'd1;
         stat_q <= scnt_q[stat_sel];
      end
   end

   assign stat_cnt = stat_q;
`endif

endmodule

// File: tb/tb_rng_sched.sv
// Bench for rng_sched: directed and random steps against a queue-based model.
// The bench also plays the datapath, returning a random word PIPE_LAT cycles on.
module tb_rng_sched;

   localparam int N  = 4;
   localparam int BY = 18;
   localparam int PL = 3;
   localparam int FD = 4;
   localparam int TW = 2;

   logic          clock = 1'b0;
   logic          rst_n = 1'b0;
   logic          en = 1'b0;
   logic [N-1:0]  req = '0;
   logic [N-1:0]  gnt;
   logic          urng_valid = 1'b0;
   logic          urng_ready;
   logic          pipe_issue;
   logic [TW-1:0] pipe_tag;
   logic          pipe_out_valid = 1'b0;
   logic [BY-1:0] pipe_out_data = '0;
   logic          out_valid;
   logic [BY-1:0] out_data;
   logic [TW-1:0] out_tag;
   logic          out_ready = 1'b0;
   logic          busy;
   logic          err;
`ifdef RNG_SCHED_STATS_EN
   logic [TW-1:0] stat_sel = '0;
   logic [31:0]   stat_cnt;
`endif

   always #5 clock = ~clock;

   rng_sched #(.N_REQ(N), .BY(BY), .PIPE_LAT(PL), .FIFO_DEPTH(FD)) dut (
      .clock          (clock),
      .rst_n          (rst_n),
      .en             (en),
      .req            (req),
      .gnt            (gnt),
      .urng_valid     (urng_valid),
      .urng_ready     (urng_ready),
      .pipe_issue     (pipe_issue),
      .pipe_tag       (pipe_tag),
      .pipe_out_valid (pipe_out_valid),
      .pipe_out_data  (pipe_out_data),
      .out_valid      (out_valid),
      .out_data       (out_data),
      .out_tag        (out_tag),
      .out_ready      (out_ready),
      .busy           (busy),
      .err            (err)
`ifdef RNG_SCHED_STATS_EN
      ,
      .stat_sel       (stat_sel),
      .stat_cnt       (stat_cnt)
`endif
   );

   typedef struct {
      int due;
      int tag;
   } inf_t;

   typedef struct {
      logic [BY-1:0] d;
      int            tag;
   } ff_t;

   int   n_cmp = 0;
   int   n_bad = 0;
   int   cyc = 0;
   int   mstate = 0;
   int   mptr = 0;
   bit   merr = 1'b0;
   inf_t infl[$];
   ff_t  fifo[$];

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step(input bit e, input logic [N-1:0] r, input bit uv,
                       input bit ordy, input bit inj);
      bit iss, due;
      int g, nin;
      @(negedge clock);
      en         = e;
      req        = r;
      urng_valid = uv;
      out_ready  = ordy;
      due = (infl.size() > 0) && (infl[0].due == cyc);
      pipe_out_valid = due ^ inj;
      pipe_out_data  = BY'($urandom);
      #1;
      g = 0;
      for (int i = N - 1; i >= 0; i--)
         if (r[(mptr + i) % N]) g = (mptr + i) % N;
      iss = (mstate == 1) && uv && (r != 0) &&
            (infl.size() + fifo.size() < FD);
      chk("gnt", gnt, iss ? (1 << g) : 0);
      chk("pipe_issue", pipe_issue, iss);
      chk("urng_ready", urng_ready, iss);
      if (iss) chk("pipe_tag", pipe_tag, g);
      chk("out_valid", out_valid, fifo.size() > 0);
      if (fifo.size() > 0) begin
         chk("out_data", out_data, fifo[0].d);
         chk("out_tag", out_tag, fifo[0].tag);
      end
      chk("busy", busy, mstate != 0);
      chk("err", err, merr);
      nin = infl.size();
      if (inj) merr = 1'b1;
      if (fifo.size() > 0 && ordy) void'(fifo.pop_front());
      if (due) begin
         fifo.push_back('{d: pipe_out_data, tag: infl[0].tag});
         void'(infl.pop_front());
      end
      if (iss) begin
         infl.push_back('{due: cyc + PL, tag: g});
         mptr = (g + 1) % N;
      end
      case (mstate)
         0: if (e) mstate = 1;
         1: if (!e) mstate = 2;
         default: begin
            if (e) mstate = 1;
            else if (nin == 0) mstate = 0;
         end
      endcase
      cyc++;
   endtask

   task automatic do_reset();
      @(negedge clock);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_err", err, 0);
      chk("rst_busy", busy, 0);
      chk("rst_gnt", gnt, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_out_tag", out_tag, 0);
      infl.delete();
      fifo.delete();
      mstate = 0;
      mptr   = 0;
      merr   = 1'b0;
      en     = 1'b0;
      pipe_out_valid = 1'b0;
      @(negedge clock);
      rst_n = 1'b1;
   endtask

   initial begin
      #3;
      chk("init_out_valid", out_valid, 0);
      chk("init_busy", busy, 0);
      chk("init_err", err, 0);
      chk("init_gnt", gnt, 0);
      @(negedge clock);
      rst_n = 1'b1;

      // single requester streaming
      for (int i = 0; i < 20; i++) step(1, 4'b0100, 1, 1, 0);
      // all requesters, consumer ready
      for (int i = 0; i < 16; i++) step(1, 4'b1111, 1, 1, 0);
      // back-pressure fills the FIFO, then one pop
      for (int i = 0; i < 12; i++) step(1, 4'b1111, 1, 0, 0);
      step(1, 4'b1111, 1, 1, 0);
      for (int i = 0; i < 6; i++) step(1, 4'b1111, 1, 0, 0);
      for (int i = 0; i < 10; i++) step(1, 4'b1111, 1, 1, 0);

      // URNG gaps hold the pointer
      do_reset();
      step(1, 4'b0011, 0, 1, 0);
      step(1, 4'b0011, 1, 1, 0);
      step(1, 4'b0011, 0, 1, 0);
      step(1, 4'b0011, 0, 1, 0);
      step(1, 4'b0011, 1, 1, 0);
      for (int i = 0; i < 6; i++) step(1, 4'b0011, 0, 1, 0);

      // drain after three issues, samples still delivered in IDLE
      do_reset();
      step(1, 4'b0001, 0, 0, 0);
      for (int i = 0; i < 3; i++) step(1, 4'b0001, 1, 0, 0);
      for (int i = 0; i < 6; i++) step(0, 4'b0001, 1, 0, 0);
      for (int i = 0; i < 5; i++) step(0, 4'b0001, 1, 1, 0);

      // random traffic
      for (int i = 0; i < 300; i++)
         step($urandom_range(0, 9) != 0, N'($urandom),
              $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, 0);

      // alignment fault is sticky, then reset mid-stream
      for (int i = 0; i < 6; i++) step(1, 4'b1011, 1, 1, 0);
      step(1, 4'b1011, 1, 1, 1);
      for (int i = 0; i < 6; i++) step(1, 4'b1011, 1, $urandom_range(0, 1), 0);
      do_reset();
      for (int i = 0; i < 8; i++) step(1, 4'b1010, 1, 1, 0);
      for (int i = 0; i < 8; i++) step(0, 4'b1010, 1, 1, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
